// File: rtl/mmio_bridge.sv
// mmio_bridge: stalls the CPU and forwards accesses above LOCAL_LIMIT to one of
// N_CH peripheral channels, with an ack timeout that returns DEADBEEF and flags err.
module mmio_bridge #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          N_CH        = 4,
    parameter logic [31:0] LOCAL_LIMIT = 32'h0000_2000,
    parameter int          CH_LSB      = 4,
    parameter int          TIMEOUT     = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     re,
    input  logic                     we,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     stall,
    output logic [N_CH-1:0]          p_req,
    output logic                     p_we,
    output logic [ADDR_W-1:0]        p_addr,
    output logic [DATA_W-1:0]        p_wdata,
    input  logic [N_CH*DATA_W-1:0]   p_rdata,
    input  logic [N_CH-1:0]          p_ack,
    output logic                     err,
    output logic [ADDR_W-1:0]        err_addr
);
    localparam int CH_W = $clog2(N_CH);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] RD_IDLE = DATA_W'(32'h0000_DEAD);
    localparam logic [DATA_W-1:0] RD_TO   = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_err_addr;
    logic [DATA_W-1:0] r_wdata, r_data, w_slice;
    logic              r_we, r_err;
    logic [CH_W-1:0]   r_ch;
    logic [TW-1:0]     r_timer;
    logic              w_ext, w_ack, w_to;

    assign w_ext = (re | we) && (addr >= ADDR_W'(LOCAL_LIMIT));
    assign w_ack = p_ack[r_ch];
    assign w_to  = (r_timer == TW'(TIMEOUT - 1)) && !w_ack;

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < N_CH; k++)
            if (CH_W'(k) == r_ch) w_slice = p_rdata[k*DATA_W +: DATA_W];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_ext ? BUSY : IDLE;
            BUSY:    w_next = (w_ack || w_to) ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    // rst_n gates the same-cycle stall so a held CPU request cannot stall during reset
    assign stall    = (r_state == BUSY) || (r_state == IDLE && w_ext && rst_n);
    assign p_req    = (r_state == BUSY) ? ({{(N_CH-1){1'b0}}, 1'b1} << r_ch) : '0;
    assign p_we     = (r_state == BUSY) && r_we;
    assign p_addr   = r_addr;
    assign p_wdata  = r_wdata;
    assign rdata    = (r_state == DONE) ? r_data : RD_IDLE;
    assign err      = (r_state == DONE) && r_err;
    assign err_addr = r_err_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_ch       <= '0;
            r_timer    <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_ext) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= we;
                r_ch    <= addr[CH_LSB +: CH_W];
                r_timer <= '0;
            end
            if (r_state == BUSY) begin
                if (r_timer != TW'(TIMEOUT)) r_timer <= r_timer + 1'b1;
                r_data <= w_ack ? (r_we ? '0 : w_slice) : RD_TO;
                r_err  <= w_to;
                if (w_to) r_err_addr <= r_addr;
            end
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: transaction-level model of the bridge drives directed accesses and
// a negedge compare process checks every output every cycle.
module tb_mmio_bridge;
    logic         clk = 0;
    logic         rst_n;
    logic [31:0]  addr, wdata, rdata, p_addr, p_wdata, err_addr;
    logic         re, we, stall, p_we, err;
    logic [3:0]   p_req, p_ack;
    logic [127:0] p_rdata;

    mmio_bridge dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
        .rdata(rdata), .stall(stall), .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic        e_stall, e_pwe, e_busy, e_err, exp_on = 0;
    logic [3:0]  e_preq;
    logic [31:0] e_paddr, e_pwdata, e_rdata, m_err_addr;
    int          run = 0, last_run = 0, err_cnt = 0;
    logic [31:0] last_rdata = 0;
    logic [3:0]  last_preq = 0;
    logic        last_pwe = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, ex, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setx(input logic s, input logic [3:0] pr, input logic pw, input logic b,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic er);
        e_stall = s; e_preq = pr; e_pwe = pw; e_busy = b;
        e_paddr = a; e_pwdata = wd; e_rdata = rd; e_err = er;
    endtask

    always @(negedge clk) if (exp_on) begin
        chk("stall", stall, e_stall);
        chk("p_req", p_req, e_preq);
        chk("p_we", p_we, e_pwe);
        chk("rdata", rdata, e_rdata);
        chk("err", err, e_err);
        chk("err_addr", err_addr, m_err_addr);
        if (e_busy) begin
            chk("p_addr", p_addr, e_paddr);
            chk("p_wdata", p_wdata, e_pwdata);
        end
        if (stall) run++;
        else if (run != 0) begin
            last_run = run;
            last_rdata = rdata;
            run = 0;
        end
        if (p_req != 0) begin
            last_preq = p_req;
            last_pwe = p_we;
        end
        if (err) err_cnt++;
    end

    // ack_at = BUSY cycle (1-based) in which the selected channel acks; outside 1..15 means never
    task automatic access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] wd,
                          input int ack_at, input logic [3:0] noise, input logic [31:0] d);
        logic ext, to;
        int ch, n;
        ext = (r | w) && a >= 32'h0000_2000;
        ch = int'(a[5:4]);
        addr = a; re = r; we = w; wdata = wd; p_ack = 0;
        setx(ext, 4'b0, 1'b0, 1'b0, 0, 0, 32'h0000_DEAD, 1'b0);
        tick;
        if (ext) begin
            to = !(ack_at >= 1 && ack_at <= 15);
            n = to ? 15 : ack_at;
            for (int i = 1; i <= n; i++) begin
                p_rdata = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
                p_rdata[ch*32 +: 32] = d;
                p_ack = noise | ((i == ack_at) ? 4'(1 << ch) : 4'b0);
                setx(1'b1, 4'(1 << ch), w, 1'b1, a, wd, 32'h0000_DEAD, 1'b0);
                tick;
            end
            p_ack = 0;
            if (to) m_err_addr = a;
            setx(1'b0, 4'b0, 1'b0, 1'b0, 0, 0, to ? 32'hDEAD_BEEF : (w ? 32'h0 : d), to);
            tick;
        end
        re = 0; we = 0;
        setx(1'b0, 4'b0, 1'b0, 1'b0, 0, 0, 32'h0000_DEAD, 1'b0);
    endtask

    initial begin
        rst_n = 0; re = 0; we = 0; addr = 0; wdata = 0; p_ack = 0; p_rdata = 0;
        m_err_addr = 0;
        setx(1'b0, 4'b0, 1'b0, 1'b0, 0, 0, 32'h0000_DEAD, 1'b0);
        exp_on = 1;
        tick; tick;
        chk("reset_rdata", rdata, 32'h0000_DEAD);
        chk("reset_err_addr", err_addr, 32'h0);
        rst_n = 1;

        access(32'h0000_C010, 1, 0, 0, 2, 4'b0100, 32'h1234_5678);
        chk("rd_ch1_stall_cycles", last_run, 3);
        chk("rd_ch1_rdata", last_rdata, 32'h1234_5678);
        chk("rd_ch1_p_req", last_preq, 4'b0010);

        access(32'h0000_C030, 1, 1, 32'hA5A5_0001, 3, 4'b0001, 32'h7777_7777);
        chk("wr_ch3_p_req", last_preq, 4'b1000);
        chk("wr_ch3_p_we", last_pwe, 1'b1);
        chk("wr_ch3_rdata", last_rdata, 32'h0);

        access(32'h0000_1FFC, 1, 0, 0, 1, 4'b0, 32'h5555_5555);
        access(32'h0000_2000, 1, 0, 0, 1, 4'b0, 32'hCAFE_0000);
        chk("boundary_stall_cycles", last_run, 2);
        chk("boundary_rdata", last_rdata, 32'hCAFE_0000);

        access(32'h0000_C020, 1, 0, 0, 0, 4'b0, 32'h9999_9999);
        chk("timeout_err_pulses", err_cnt, 1);
        chk("timeout_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("timeout_err_addr", err_addr, 32'h0000_C020);
        chk("timeout_stall_cycles", last_run, 16);

        access(32'h0000_C020, 1, 0, 0, 15, 4'b0, 32'hBEEF_0015);
        chk("late_ack_err_pulses", err_cnt, 1);
        chk("late_ack_rdata", last_rdata, 32'hBEEF_0015);
        chk("late_ack_stall_cycles", last_run, 16);

        access(32'h0000_C030, 1, 0, 0, 4, 4'b0001, 32'h3333_0003);
        chk("foreign_ack_stall_cycles", last_run, 5);
        chk("foreign_ack_rdata", last_rdata, 32'h3333_0003);

        addr = 32'h0000_C020; re = 1; we = 0; p_ack = 0;
        setx(1'b1, 4'b0, 1'b0, 1'b0, 0, 0, 32'h0000_DEAD, 1'b0);
        tick;
        for (int i = 1; i <= 2; i++) begin
            setx(1'b1, 4'b0100, 1'b0, 1'b1, 32'h0000_C020, 32'h0, 32'h0000_DEAD, 1'b0);
            tick;
        end
        chk("pre_reset_p_req", p_req, 4'b0100);
        rst_n = 0;
        m_err_addr = 0;
        setx(1'b0, 4'b0, 1'b0, 1'b0, 0, 0, 32'h0000_DEAD, 1'b0);
        #1;
        chk("mid_reset_p_req", p_req, 4'b0);
        chk("mid_reset_stall", stall, 1'b0);
        chk("mid_reset_err", err, 1'b0);
        tick; tick;
        re = 0;
        rst_n = 1;

        access(32'h0000_C010, 0, 1, 32'h1111_2222, 1, 4'b0, 32'h0);
        chk("post_reset_stall_cycles", last_run, 2);
        chk("post_reset_p_req", last_preq, 4'b0010);
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 32, address bus width.
REQ-003 SHALL have parameter N_CH, default 4, peripheral channel count; power of 2, at least 2.
REQ-004 SHALL have parameter LOCAL_LIMIT, default 32'h0000_2000; addresses below this value belong to internal DM and the bridge ignores them.
REQ-005 SHALL have parameter CH_LSB, default 4, LSB of the channel field addr[CH_LSB +: log2(N_CH)].
REQ-006 SHALL have parameter TIMEOUT, default 15, maximum BUSY cycles spent waiting for an ack; at least 1.
REQ-007 SHALL have port clk, input, 1: the single clock; all flops on the rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port addr, input, ADDR_W: CPU data address, EX/DM stage.
REQ-010 SHALL have ports re and we, input, 1 each: CPU read and write enables.
REQ-011 SHALL have port wdata, input, DATA_W: CPU store data.
REQ-012 SHALL have port rdata, output, DATA_W: read data returned to CPU.
REQ-013 SHALL have port stall, output, 1: freezes the CPU pipeline while high.
REQ-014 SHALL have port p_req, output, N_CH: one-hot per-channel request.
REQ-015 SHALL have ports p_we (output, 1), p_addr (output, ADDR_W) and p_wdata (output, DATA_W): shared peripheral bus.
REQ-016 SHALL have port p_rdata, input, N_CH*DATA_W; channel k occupies [k*DATA_W +: DATA_W].
REQ-017 SHALL have port p_ack, input, N_CH: per-channel completion.
REQ-018 SHALL have port err, output, 1: one-cycle timeout pulse.
REQ-019 SHALL have port err_addr, output, ADDR_W: address of the last timed-out access.

Function
REQ-020 SHALL define an external access as (re|we) && addr >= LOCAL_LIMIT, unsigned comparison.
REQ-021 SHALL implement FSM states IDLE, BUSY and DONE; encoding is free.
REQ-022 In IDLE, on an external access, SHALL drive stall=1 combinationally in the same cycle; latch addr, wdata, we and channel; then go to BUSY.
REQ-023 SHALL treat re&we together as a write.
REQ-024 In IDLE with no access or a local access, SHALL hold stall=0 and remain in IDLE.
REQ-025 In BUSY, SHALL drive p_req[ch]=1 with all other bits 0 and stall=1, and drive p_we/p_addr/p_wdata from latched values, held stable until BUSY is exited.
REQ-026 Outside BUSY, SHALL drive p_req=0 and p_we=0; p_addr/p_wdata are don't-care.
REQ-027 In BUSY, on p_ack[ch]=1, SHALL capture the p_rdata slice for ch (reads) or 0 (writes), then go to DONE; p_ack on unselected channels SHALL be ignored.
REQ-028 SHALL clear the timer to 0 on entry to BUSY and increment it each BUSY cycle; width is clog2(TIMEOUT+1); the timer SHALL never wrap.
REQ-029 In the BUSY cycle where timer==TIMEOUT-1 with no ack: capture 32'hDEAD_BEEF (resized to DATA_W), set err_addr=latched addr, then go to DONE; err SHALL be 1 for exactly that DONE cycle.
REQ-030 If ack and timeout coincide, ack SHALL win: normal data, no err.
REQ-031 In DONE, SHALL drive stall=0 and rdata=captured data; CPU requests SHALL be ignored this cycle (the CPU retires the held access); next state is IDLE.
REQ-032 In every state except DONE, SHALL drive rdata=32'h0000_DEAD (resized to DATA_W).
REQ-033 For a read acked in the first BUSY cycle, SHALL hold stall high for 2 cycles and present data on the 3rd cycle; the minimum external access takes 3 cycles.
REQ-034 err_addr SHALL hold its value until the next timeout.

Reset
REQ-035 While rst_n=0, SHALL hold state=IDLE, stall=0, p_req=0, p_we=0, rdata=32'h0000_DEAD, err=0, err_addr=0, timer=0, asynchronously.
REQ-036 Reset asserted mid-BUSY SHALL drop p_req immediately with no err; after release, SHALL restart in IDLE.
REQ-037 SHALL be fully functional in the first cycle after rst_n rises.

Verification
REQ-038 Read addr=32'h0000_C010 (channel 1), p_ack[1] after 2 BUSY cycles with p_rdata slice 1=32'h1234_5678 -> p_req=4'b0010, stall high 3 cycles, rdata=32'h1234_5678 in DONE.
REQ-039 Write addr=32'h0000_C030, wdata=32'hA5A5_0001, re=we=1 -> p_we=1, p_addr/p_wdata stable for all BUSY cycles, p_req=4'b1000.
REQ-040 Local read addr=32'h0000_1FFC -> stall=0, p_req=0 throughout; boundary addr=32'h0000_2000 -> external access.
REQ-041 No ack on channel 2 -> after 15 BUSY cycles err pulses once, rdata=32'hDEAD_BEEF, err_addr=addr; ack in the 15th BUSY cycle -> no err.
REQ-042 p_ack[0] asserted while channel 3 is selected -> ignored, FSM stays in BUSY.
REQ-043 rst_n low in the 3rd BUSY cycle -> p_req=0 and stall=0 immediately; next access completes normally.
